// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // Lowest enabled channel at or above 'from'; MSB of the result is the found flag.
  function automatic logic [SEL_W:0] first_en(input logic [NUM_CH-1:0] mask,
                                              input int unsigned from);
    logic found;
    ch_t  idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!found && k >= from && mask[k[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = k[SEL_W-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux_scan_seq_if.sv
// Scan control, mux select/sample and result handshake bundle for mux_scan_seq.
interface mux_scan_seq_if;
  import mux_scan_pkg::*;

  logic                start;
  logic                cont;
  logic [NUM_CH-1:0]   ch_mask;
  logic                y;
  logic                s1;
  logic                s0;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_CH-1:0]   out_data;
  logic [7:0]          scan_cnt;

  modport master (
    output start, cont, ch_mask, y, out_ready,
    input  s1, s0, busy, out_valid, out_data, scan_cnt
  );

  modport slave (
    input  start, cont, ch_mask, y, out_ready,
    output s1, s0, busy, out_valid, out_data, scan_cnt
  );

endinterface

// File: rtl/mux_dwell_timer.sv
// Dwell down-counter: load sets DWELL-1, counts down to 0 and holds; done when 0.
module mux_dwell_timer #(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= 8'(DWELL - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Scans a downstream 4:1 mux by stepping {s1,s0}, sampling y after DWELL cycles per channel.
// Optional MUX_SCAN_SKIP_EN: channels with ch_mask bit 0 are skipped and read as 0.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_scan_seq_if.slave bus
);

  state_t            state_q, state_d;
  ch_t               ch_q, ch_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              load;
  logic              done;
  logic              first_ok, next_ok;
  ch_t               first_ch, next_ch;

  mux_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .done (done)
  );

  // Channel ordering is resolved here so the FSM below is identical in both builds.
`ifdef MUX_SCAN_SKIP_EN
  assign {first_ok, first_ch} = first_en(bus.ch_mask, 0);
  assign {next_ok, next_ch}   = first_en(bus.ch_mask, int unsigned'(ch_q) + 1);
`else
  logic unused_mask;
  assign unused_mask = ^bus.ch_mask;
  assign first_ok    = 1'b1;
  assign first_ch    = '0;
  assign next_ok     = (ch_q != ch_t'(NUM_CH - 1));
  assign next_ch     = ch_q + ch_t'(1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          data_d = '0;
          ch_d   = first_ch;
          load   = first_ok;
          state_d = first_ok ? SETTLE : HOLD;
        end
      end
      SETTLE: begin
        if (done) begin
          data_d[ch_q] = bus.y;
          if (next_ok) begin
            ch_d = next_ch;
            load = 1'b1;
          end else begin
            ch_d    = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (bus.cont) begin
            data_d  = '0;
            ch_d    = first_ch;
            load    = first_ok;
            state_d = first_ok ? SETTLE : HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {bus.s1, bus.s0} = (state_q == SETTLE) ? ch_q : '0;
  assign bus.busy         = (state_q != IDLE);
  assign bus.out_valid    = (state_q == HOLD);
  assign bus.out_data     = data_q;
  assign bus.scan_cnt     = cnt_q;

endmodule
